// File: rtl/conj_demod_pkg.sv
// Shared types and helpers for the conjugate-product discriminator scheduler.
package conj_demod_pkg;

  localparam int IQ_W = 32;

  typedef struct packed {
    logic signed [15:0] im;
    logic signed [15:0] re;
  } iq_t;

  typedef logic signed [32:0] prod_t;

  localparam prod_t SAT_MAX = prod_t'(32767);
  localparam prod_t SAT_MIN = prod_t'(-32768);

  function automatic logic signed [15:0] sat16(prod_t v, int shift);
    prod_t s;
    s = v >>> shift;
    if (s > SAT_MAX)      sat16 = 16'sh7fff;
    else if (s < SAT_MIN) sat16 = 16'sh8000;
    else                  sat16 = s[15:0];
  endfunction

endpackage

// File: rtl/conj_demod_sched_if.sv
// AXIS bundle: NUM_CH input streams in, one tagged product stream out.
interface conj_demod_sched_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
);
  logic [NUM_CH-1:0]    s00_axis_tvalid;
  logic [NUM_CH-1:0]    s00_axis_tready;
  logic [NUM_CH*32-1:0] s00_axis_tdata;
  logic [NUM_CH-1:0]    s00_axis_tlast;
  logic                 m00_axis_tready;
  logic                 m00_axis_tvalid;
  logic [31:0]          m00_axis_tdata;
  logic                 m00_axis_tlast;
  logic [CH_W-1:0]      m00_axis_tuser;

  modport slave (
    input  s00_axis_tvalid, s00_axis_tdata, s00_axis_tlast, m00_axis_tready,
    output s00_axis_tready, m00_axis_tvalid, m00_axis_tdata, m00_axis_tlast, m00_axis_tuser
  );

  modport master (
    output s00_axis_tvalid, s00_axis_tdata, s00_axis_tlast, m00_axis_tready,
    input  s00_axis_tready, m00_axis_tvalid, m00_axis_tdata, m00_axis_tlast, m00_axis_tuser
  );
endinterface

// File: rtl/conj_demod_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// pointer moves past the winner on every grant.
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  input  logic         adv_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] grant_idx_o,
  output logic         grant_vld_o
);

  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] cand;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    cand        = '0;
    ptr_d       = ptr_q;
    for (int k = 0; k < N; k++) begin
      cand = W'((int'(ptr_q) + k) % N);
      if (adv_i && !grant_vld_o && req_i[cand]) begin
        grant_vld_o = 1'b1;
        grant_idx_o = cand;
      end
    end
    if (grant_vld_o) begin
      grant_o[grant_idx_o] = 1'b1;
      ptr_d = (int'(grant_idx_o) == N - 1) ? '0 : grant_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/conj_demod_sched.sv
// Shared y[n]*conj(y[n-1]) discriminator for NUM_CH AXIS IQ streams.
// Optional frame priming is enabled with `define CONJ_SCHED_PRIME_EN.
module conj_demod_sched
  import conj_demod_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int OUT_SHIFT = 15
) (
  input logic               s00_axis_aclk,
  input logic               s00_axis_aresetn,
  conj_demod_sched_if.slave axis
);

  localparam int CH_W = $clog2(NUM_CH);

  logic              adv;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   gidx;
  logic              gvld;
  iq_t               in_smp;
  logic              in_last;
  logic              s1_emit;

  // Holding adv low in reset keeps upstream tready at zero.
  assign adv = s00_axis_aresetn & (~axis.m00_axis_tvalid | axis.m00_axis_tready);

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk_i       (s00_axis_aclk),
    .rst_ni      (s00_axis_aresetn),
    .req_i       (axis.s00_axis_tvalid),
    .adv_i       (adv),
    .grant_o     (grant),
    .grant_idx_o (gidx),
    .grant_vld_o (gvld)
  );

  assign axis.s00_axis_tready = grant;
  assign in_smp  = iq_t'(axis.s00_axis_tdata[int'(gidx) * IQ_W +: IQ_W]);
  assign in_last = axis.s00_axis_tlast[gidx];

  iq_t hist_q [NUM_CH];

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      for (int i = 0; i < NUM_CH; i++) hist_q[i] <= '0;
    end else if (gvld) begin
      hist_q[gidx] <= in_smp;
    end
  end

`ifdef CONJ_SCHED_PRIME_EN
  logic [NUM_CH-1:0] primed_q;

  assign s1_emit = gvld & primed_q[gidx];

  // An unprimed sample only seeds history; a tlast sample re-arms priming.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn)  primed_q <= '0;
    else if (gvld)          primed_q[gidx] <= primed_q[gidx] ? ~in_last : 1'b1;
  end
`else
  assign s1_emit = gvld;
`endif

  logic            s1_vld_q;
  iq_t             s1_cur_q, s1_prev_q;
  logic [CH_W-1:0] s1_ch_q;
  logic            s1_last_q;

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      s1_vld_q  <= 1'b0;
      s1_cur_q  <= '0;
      s1_prev_q <= '0;
      s1_ch_q   <= '0;
      s1_last_q <= 1'b0;
    end else if (adv) begin
      s1_vld_q <= s1_emit;
      if (gvld) begin
        s1_cur_q  <= in_smp;
        s1_prev_q <= hist_q[gidx];
        s1_ch_q   <= gidx;
        s1_last_q <= in_last;
      end
    end
  end

  logic signed [31:0] p_ii, p_qq, p_qi, p_iq;
  prod_t              s2_re_d, s2_im_d;

  assign p_ii    = $signed(s1_cur_q.re) * $signed(s1_prev_q.re);
  assign p_qq    = $signed(s1_cur_q.im) * $signed(s1_prev_q.im);
  assign p_qi    = $signed(s1_cur_q.im) * $signed(s1_prev_q.re);
  assign p_iq    = $signed(s1_cur_q.re) * $signed(s1_prev_q.im);
  assign s2_re_d = prod_t'(p_ii) + prod_t'(p_qq);
  assign s2_im_d = prod_t'(p_qi) - prod_t'(p_iq);

  logic            s2_vld_q;
  prod_t           s2_re_q, s2_im_q;
  logic [CH_W-1:0] s2_ch_q;
  logic            s2_last_q;

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      s2_vld_q  <= 1'b0;
      s2_re_q   <= '0;
      s2_im_q   <= '0;
      s2_ch_q   <= '0;
      s2_last_q <= 1'b0;
    end else if (adv) begin
      s2_vld_q  <= s1_vld_q;
      s2_re_q   <= s2_re_d;
      s2_im_q   <= s2_im_d;
      s2_ch_q   <= s1_ch_q;
      s2_last_q <= s1_last_q;
    end
  end

  logic            out_vld_q;
  iq_t             out_data_q;
  logic [CH_W-1:0] out_user_q;
  logic            out_last_q;

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_user_q <= '0;
      out_last_q <= 1'b0;
    end else if (adv) begin
      out_vld_q <= s2_vld_q;
      if (s2_vld_q) begin
        out_data_q.re <= sat16(s2_re_q, OUT_SHIFT);
        out_data_q.im <= sat16(s2_im_q, OUT_SHIFT);
        out_user_q    <= s2_ch_q;
        out_last_q    <= s2_last_q;
      end
    end
  end

  assign axis.m00_axis_tvalid = out_vld_q;
  assign axis.m00_axis_tdata  = out_data_q;
  assign axis.m00_axis_tuser  = out_user_q;
  assign axis.m00_axis_tlast  = out_last_q;

endmodule

// File: tb/tb_conj_demod_sched.sv
// Scoreboard bench for conj_demod_sched: a reference model queues each expected
// product at input accept; outputs are popped and compared as they appear.
module tb_conj_demod_sched;
  localparam int NUM_CH    = 4;
  localparam int OUT_SHIFT = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conj_demod_sched_if #(.NUM_CH(NUM_CH)) axis ();

  conj_demod_sched #(.NUM_CH(NUM_CH), .OUT_SHIFT(OUT_SHIFT)) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .axis             (axis)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  user;
    logic        last;
  } exp_t;

  exp_t              sb[$];
  logic [31:0]       hist_m [NUM_CH];
  logic [NUM_CH-1:0] primed_m;
  int                ptr_m  = 0;
  int                checks = 0;
  int                errors = 0;
  int                cyc    = 0;

  logic [31:0] got_data[$];
  logic [1:0]  got_user[$];
  logic        got_last[$];
  int          got_cyc[$];

  always @(posedge clk) cyc++;

  function automatic logic [15:0] msat(longint v);
    longint s;
    s = v >>> OUT_SHIFT;
    if (s > 32767)  return 16'h7fff;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  // Reference model and scoreboard
  always @(negedge clk) begin : mon
    logic [31:0] cur, prv;
    longint      ci, cq, pi, pq, re, im;
    bit          emit;
    exp_t        e;
    if (rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (axis.s00_axis_tvalid[c] && axis.s00_axis_tready[c]) begin
          cur = axis.s00_axis_tdata[32*c +: 32];
          prv = hist_m[c];
          ci = longint'($signed(cur[15:0]));
          cq = longint'($signed(cur[31:16]));
          pi = longint'($signed(prv[15:0]));
          pq = longint'($signed(prv[31:16]));
          re = ci * pi + cq * pq;
          im = cq * pi - ci * pq;
          emit = 1'b1;
`ifdef CONJ_SCHED_PRIME_EN
          emit = primed_m[c];
          primed_m[c] = primed_m[c] ? ~axis.s00_axis_tlast[c] : 1'b1;
`endif
          hist_m[c] = cur;
          ptr_m = (c + 1) % NUM_CH;
          if (emit) begin
            e.data = {msat(im), msat(re)};
            e.user = 2'(c);
            e.last = axis.s00_axis_tlast[c];
            sb.push_back(e);
          end
        end
      end
      if (axis.m00_axis_tvalid && axis.m00_axis_tready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got data=%h user=%0d last=%0b, required no output",
                   axis.m00_axis_tdata, axis.m00_axis_tuser, axis.m00_axis_tlast);
        end else begin
          e = sb.pop_front();
          if ({axis.m00_axis_tdata, axis.m00_axis_tuser, axis.m00_axis_tlast} !== {e.data, e.user, e.last}) begin
            errors++;
            $display("FAIL sb_output: got data=%h user=%0d last=%0b, required data=%h user=%0d last=%0b",
                     axis.m00_axis_tdata, axis.m00_axis_tuser, axis.m00_axis_tlast, e.data, e.user, e.last);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic clear_model();
    sb.delete();
    for (int c = 0; c < NUM_CH; c++) hist_m[c] = '0;
    primed_m = '0;
    ptr_m    = 0;
  endtask

  task automatic clear_got();
    got_data.delete();
    got_user.delete();
    got_last.delete();
    got_cyc.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    axis.s00_axis_tvalid = '0;
    axis.s00_axis_tlast  = '0;
    axis.m00_axis_tready = 1'b1;
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send(input int ch, input logic [31:0] d, input logic last, output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    axis.s00_axis_tvalid[ch]         = 1'b1;
    axis.s00_axis_tdata[32*ch +: 32] = d;
    axis.s00_axis_tlast[ch]          = last;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (axis.s00_axis_tready[ch]) begin
        ok  = 1'b1;
        acc = cyc;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_accept: ch %0d tready=0 after 20 cycles, required 1", ch);
    end
    @(posedge clk); #1;
    axis.s00_axis_tvalid[ch] = 1'b0;
    axis.s00_axis_tlast[ch]  = 1'b0;
  endtask

  task automatic collect(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (axis.m00_axis_tvalid && axis.m00_axis_tready) begin
        got_data.push_back(axis.m00_axis_tdata);
        got_user.push_back(axis.m00_axis_tuser);
        got_last.push_back(axis.m00_axis_tlast);
        got_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic drain(output int left);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !axis.m00_axis_tvalid) break;
    end
    left = sb.size();
    @(posedge clk); #1;
  endtask

  task automatic run_all_cycles(input int n);
    logic [NUM_CH-1:0] acc;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      acc = axis.s00_axis_tready;
      @(posedge clk); #1;
      for (int c = 0; c < NUM_CH; c++)
        if (acc[c]) axis.s00_axis_tdata[32*c +: 32] = $urandom();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    axis.s00_axis_tvalid = '1;
    axis.s00_axis_tdata  = '0;
    axis.s00_axis_tlast  = '0;
    axis.m00_axis_tready = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    checks++;
    if (axis.s00_axis_tready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_s_tready: got %b, required 0000", axis.s00_axis_tready);
    end
    checks++;
    if ({axis.m00_axis_tvalid, axis.m00_axis_tdata, axis.m00_axis_tuser, axis.m00_axis_tlast} !== 36'd0) begin
      errors++;
      $display("FAIL reset_m_outputs: got valid=%0b data=%h user=%0d last=%0b, required all 0",
               axis.m00_axis_tvalid, axis.m00_axis_tdata, axis.m00_axis_tuser, axis.m00_axis_tlast);
    end
    axis.s00_axis_tvalid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int a0, a1, a2, ref_acc, left;
    clear_got();
    fork
      begin
        send(0, {16'sd0,   16'sd100},   1'b0, a0);
        send(0, {16'sd100, 16'sd0},     1'b0, a1);
        send(0, {16'sd0,   16'sd10000}, 1'b0, a2);
      end
      collect(15);
    join
    @(posedge clk); #1;
`ifdef CONJ_SCHED_PRIME_EN
    ref_acc = a1;
    checks++;
    if (got_data.size() != 2) begin
      errors++;
      $display("FAIL single_count: got %0d outputs, required 2", got_data.size());
    end
`else
    ref_acc = a0;
    checks++;
    if (got_data.size() != 3) begin
      errors++;
      $display("FAIL single_count: got %0d outputs, required 3", got_data.size());
    end
`endif
    if (got_data.size() >= 2) begin
      checks++;
      if (got_cyc[0] - ref_acc != 3) begin
        errors++;
        $display("FAIL single_latency: got %0d cycles, required 3", got_cyc[0] - ref_acc);
      end
      checks++;
      if (got_data[0] !== 32'h0000_0000 || got_user[0] !== 2'd0) begin
        errors++;
        $display("FAIL single_first: got data=%h user=%0d, required data=00000000 user=0", got_data[0], got_user[0]);
      end
      checks++;
      if (got_data[got_data.size()-1] !== 32'hffe1_0000) begin
        errors++;
        $display("FAIL single_last_val: got %h, required ffe10000", got_data[got_data.size()-1]);
      end
      checks++;
      if (got_cyc[1] - got_cyc[0] != 1) begin
        errors++;
        $display("FAIL single_b2b: got gap %0d, required 1", got_cyc[1] - got_cyc[0]);
      end
    end
    drain(left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL single_drain: got %0d pending, required 0", left);
    end
  endtask

  task automatic test_round_robin();
    int                e, left;
    int                cnt [NUM_CH];
    logic [NUM_CH-1:0] exp_r;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt[c] = 0;
      axis.s00_axis_tdata[32*c +: 32] = $urandom();
    end
    e = ptr_m;
    axis.s00_axis_tlast  = '0;
    axis.s00_axis_tvalid = '1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp_r    = '0;
      exp_r[e] = 1'b1;
      checks++;
      if (axis.s00_axis_tready !== exp_r) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %b, required %b", k, axis.s00_axis_tready, exp_r);
      end
      cnt[e]++;
      @(posedge clk); #1;
      axis.s00_axis_tdata[32*e +: 32] = $urandom();
      e = (e + 1) % NUM_CH;
    end
    axis.s00_axis_tvalid = '0;
    drain(left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL rr_drain: got %0d pending, required 0", left);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      checks++;
      if (cnt[c] != 3) begin
        errors++;
        $display("FAIL rr_fair ch%0d: got %0d grants, required 3", c, cnt[c]);
      end
    end
  endtask

  task automatic test_saturation();
    int a, left;
    clear_got();
    fork
      begin
        send(3, {16'sh7fff, 16'sh7fff}, 1'b0, a);
        send(3, {16'sh7fff, 16'sh7fff}, 1'b0, a);
        send(3, {16'sh8000, 16'sh7fff}, 1'b0, a);
      end
      collect(15);
    join
    @(posedge clk); #1;
    checks++;
    if (got_data.size() != 3) begin
      errors++;
      $display("FAIL sat_count: got %0d outputs, required 3", got_data.size());
    end else begin
      checks++;
      if (got_data[1] !== 32'h0000_7fff) begin
        errors++;
        $display("FAIL sat_pos: got %h, required 00007fff", got_data[1]);
      end
      checks++;
      if (got_data[2] !== 32'h8000_ffff || got_user[2] !== 2'd3) begin
        errors++;
        $display("FAIL sat_neg: got data=%h user=%0d, required data=8000ffff user=3", got_data[2], got_user[2]);
      end
    end
    drain(left);
  endtask

  task automatic test_backpressure();
    logic [35:0] cap;
    int          left;
    for (int c = 0; c < NUM_CH; c++) axis.s00_axis_tdata[32*c +: 32] = $urandom();
    axis.s00_axis_tlast  = '0;
    axis.s00_axis_tvalid = '1;
    run_all_cycles(6);
    axis.m00_axis_tready = 1'b0;
    cap = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (axis.s00_axis_tready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_s_tready[%0d]: got %b, required 0000", k, axis.s00_axis_tready);
      end
      if (k == 0) begin
        cap = {axis.m00_axis_tvalid, axis.m00_axis_tdata, axis.m00_axis_tuser, axis.m00_axis_tlast};
        checks++;
        if (axis.m00_axis_tvalid !== 1'b1) begin
          errors++;
          $display("FAIL bp_valid: got %0b, required 1", axis.m00_axis_tvalid);
        end
      end else begin
        checks++;
        if ({axis.m00_axis_tvalid, axis.m00_axis_tdata, axis.m00_axis_tuser, axis.m00_axis_tlast} !== cap) begin
          errors++;
          $display("FAIL bp_stable[%0d]: got %h, required %h", k,
                   {axis.m00_axis_tvalid, axis.m00_axis_tdata, axis.m00_axis_tuser, axis.m00_axis_tlast}, cap);
        end
      end
    end
    @(posedge clk); #1;
    axis.m00_axis_tready = 1'b1;
    run_all_cycles(6);
    axis.s00_axis_tvalid = '0;
    drain(left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL bp_drain: got %0d pending, required 0", left);
    end
  endtask

  task automatic test_tlast_frames();
    int          a, left, n_exp;
    logic [4:0]  exp_last;
    do_reset();
    clear_got();
    fork
      begin
        send(2, 32'h0100_0200, 1'b0, a);
        send(2, 32'h0300_0100, 1'b0, a);
        send(2, 32'hff00_0400, 1'b1, a);
        send(2, 32'h0200_fe00, 1'b0, a);
        send(2, 32'h0500_0300, 1'b0, a);
      end
      collect(20);
    join
    @(posedge clk); #1;
`ifdef CONJ_SCHED_PRIME_EN
    n_exp    = 3;
    exp_last = 5'b00010;
`else
    n_exp    = 5;
    exp_last = 5'b00100;
`endif
    checks++;
    if (got_data.size() != n_exp) begin
      errors++;
      $display("FAIL frame_count: got %0d outputs, required %0d", got_data.size(), n_exp);
    end else begin
      for (int i = 0; i < n_exp; i++) begin
        checks++;
        if (got_last[i] !== exp_last[i] || got_user[i] !== 2'd2) begin
          errors++;
          $display("FAIL frame_out[%0d]: got last=%0b user=%0d, required last=%0b user=2",
                   i, got_last[i], got_user[i], exp_last[i]);
        end
      end
    end
    drain(left);
  endtask

  task automatic test_reset_mid();
    int a, left, n_exp;
    for (int c = 0; c < NUM_CH; c++) axis.s00_axis_tdata[32*c +: 32] = $urandom();
    axis.s00_axis_tvalid = '1;
    run_all_cycles(4);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    checks++;
    if (axis.m00_axis_tvalid !== 1'b0 || axis.s00_axis_tready !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_async: got m_tvalid=%0b s_tready=%b, required 0 and 0000",
               axis.m00_axis_tvalid, axis.s00_axis_tready);
    end
    axis.s00_axis_tvalid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_got();
    fork
      begin
        send(1, 32'h1234_5678, 1'b0, a);
        send(1, 32'h0010_0020, 1'b0, a);
      end
      collect(12);
    join
    @(posedge clk); #1;
`ifdef CONJ_SCHED_PRIME_EN
    n_exp = 1;
`else
    n_exp = 2;
`endif
    checks++;
    if (got_data.size() != n_exp) begin
      errors++;
      $display("FAIL rstmid_count: got %0d outputs, required %0d", got_data.size(), n_exp);
    end
`ifndef CONJ_SCHED_PRIME_EN
    if (got_data.size() == 2) begin
      checks++;
      if (got_data[0] !== 32'h0 || got_user[0] !== 2'd1) begin
        errors++;
        $display("FAIL rstmid_first: got data=%h user=%0d, required data=00000000 user=1", got_data[0], got_user[0]);
      end
    end
`endif
    drain(left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL rstmid_drain: got %0d pending, required 0", left);
    end
  endtask

  initial begin
    axis.s00_axis_tvalid = '0;
    axis.s00_axis_tdata  = '0;
    axis.s00_axis_tlast  = '0;
    axis.m00_axis_tready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_saturation();
    test_backpressure();
    test_tlast_frames();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_sb: got %0d pending, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
